regfile_write_buffer: RTL and testbench
=======================================

REGFILE_WRITE_BUFFER -- requirements
Module: regfile_write_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending-write entries (power of two, 2..8).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  producer offers a write.
REQ-005 Port: in_ready  output  1  buffer accepts a write this cycle.
REQ-006 Port: in_rw  input  5  destination register of offered write.
REQ-007 Port: in_pw  input  32  data of offered write.
REQ-008 Port: rf_hold  input  1  when high, stalls draining into the register file.
REQ-009 Port: rf_enable  output  1  write enable to register file.
REQ-010 Port: rf_rw  output  5  write address to register file.
REQ-011 Port: rf_pw  output  32  write data to register file.
REQ-012 Port: ra, rb, rd  input  5 each  read addresses, also driven to the register file.
REQ-013 Port: rf_pa, rf_pb, rf_pd  input  32 each  raw register-file read data.
REQ-014 Port: pa, pb, pd  output  32 each  bypass-corrected read data.
REQ-015 Port: count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Buffer SHALL be a circular FIFO of {rw, pw} entries with head/tail pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH); no same-cycle pass-through when full.
REQ-018 Enqueue SHALL occur on an edge where in_valid & in_ready, and in_rw != 0; an accepted write with in_rw == 0 SHALL be discarded (count unchanged).
REQ-019 rf_enable SHALL equal (count != 0) & ~rf_hold; rf_rw/rf_pw SHALL show the head entry when count != 0, else 0.
REQ-020 Dequeue SHALL occur on every edge where rf_enable is high; the register file captures the same edge.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers both advance.
REQ-022 Latency: an accepted write SHALL appear on rf_* in the following cycle when the buffer was empty and rf_hold low.
REQ-023 Writes SHALL drain strictly in acceptance order; duplicate addresses are retained, not merged.
REQ-024 For each read port, if address != 0 and matches any occupied entry, output SHALL be pw of the youngest matching entry; otherwise output SHALL equal the corresponding rf_p* input.
REQ-025 Address 0 SHALL always pass rf_p* unchanged (register 0 reads as zero).
REQ-026 Bypass and all rf_* outputs SHALL be combinational from state and inputs; no added read latency.
REQ-027 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-028 On reset edge: head, tail, count SHALL be 0; entry storage need not be cleared.
REQ-029 After reset: in_ready=1, rf_enable=0, rf_rw=0, rf_pw=0, pa/pb/pd = rf_pa/rf_pb/rf_pd.
REQ-030 Reset SHALL dominate any simultaneous enqueue or dequeue; pending writes are dropped.

Structure
REQ-031 Shared package SHALL hold the register-address width (5), data width (32), default DEPTH and the write-entry typedef {rw, pw}.
REQ-032 One sub-module, wbuf_bypass, SHALL perform youngest-match selection for one read port; instantiate three times.

Verification
REQ-033 Reset, then in_valid=1, rw=5, pw=0xAAAA0005 for one cycle -> next cycle rf_enable=1, rf_rw=5, rf_pw=0xAAAA0005; ra=5 reads 0xAAAA0005 before drain.
REQ-034 rf_hold=1, enqueue 4 writes (rw=1..4) -> count=4, in_ready=0; 5th offer not accepted; release hold -> drains 1,2,3,4 on consecutive cycles.
REQ-035 rf_hold=1, enqueue rw=7 pw=0x11 then rw=7 pw=0x22 -> rb=7 gives 0x22; after both drain, pb follows rf_pb.
REQ-036 Enqueue rw=0 pw=0xFFFFFFFF -> count stays 0, rf_enable stays 0; rd=0 passes rf_pd.
REQ-037 Full buffer with hold low, in_valid held high -> count remains 4 never exceeded; order preserved across pointer wrap.
REQ-038 Assert reset with count=3 -> next cycle count=0, rf_enable=0, in_ready=1.

Source files
------------

// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer.
//   RW_W          - register address width
//   PW_W          - register data width
//   DEPTH_DEFAULT - default number of pending-write entries
//   wentry_t      - one pending write {rw, pw}
package regfile_write_buffer_pkg;

    localparam int RW_W          = 5;
    localparam int PW_W          = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [RW_W-1:0] rw;
        logic [PW_W-1:0] pw;
    } wentry_t;

endpackage

// File: rtl/wbuf_bypass.sv
// Youngest-match read bypass for one read port of the write buffer.
// Ports:
//   entries - raw entry storage, indexed by physical slot
//   head    - slot of the oldest occupied entry
//   count   - number of occupied entries
//   addr    - read address
//   rf_data - raw register-file read data for addr
//   data    - corrected read data (youngest pending write to addr, else rf_data)
module wbuf_bypass
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  wentry_t          entries [DEPTH],
    input  logic [PTR_W-1:0] head,
    input  logic [CNT_W-1:0] count,
    input  logic [RW_W-1:0]  addr,
    input  logic [PW_W-1:0]  rf_data,
    output logic [PW_W-1:0]  data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest; a later match overrides an earlier one,
    // so the final value is the youngest pending write to addr. DEPTH is a
    // power of two, so the pointer add wraps modulo DEPTH for free.
    always_comb begin
        data = rf_data;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr != '0) && (entries[idx].rw == addr)) begin
                data = entries[idx].pw;
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Register-file write buffer: a small circular FIFO of pending writes that
// drains into the register file whenever rf_hold is low, with read bypass so
// that reads always observe the youngest pending write.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   in_valid/in_ready     - producer write handshake
//   in_rw, in_pw          - offered write address / data
//   rf_hold               - stalls draining
//   rf_enable, rf_rw, rf_pw - write port to the register file (head entry)
//   ra, rb, rd            - read addresses (shared with the register file)
//   rf_pa, rf_pb, rf_pd   - raw register-file read data
//   pa, pb, pd            - bypass-corrected read data
//   count                 - occupied entries
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW_W-1:0]  in_rw,
    input  logic [PW_W-1:0]  in_pw,
    input  logic             rf_hold,
    output logic             rf_enable,
    output logic [RW_W-1:0]  rf_rw,
    output logic [PW_W-1:0]  rf_pw,
    input  logic [RW_W-1:0]  ra,
    input  logic [RW_W-1:0]  rb,
    input  logic [RW_W-1:0]  rd,
    input  logic [PW_W-1:0]  rf_pa,
    input  logic [PW_W-1:0]  rf_pb,
    input  logic [PW_W-1:0]  rf_pd,
    output logic [PW_W-1:0]  pa,
    output logic [PW_W-1:0]  pb,
    output logic [PW_W-1:0]  pd,
    output logic [CNT_W-1:0] count
);

    wentry_t          entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;

    // in_ready depends only on occupancy, never on in_valid.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign rf_enable = (count != '0) && !rf_hold;

    // Writes to register 0 complete the handshake but are dropped.
    assign enq = in_valid && in_ready && (in_rw != '0);
    assign deq = rf_enable;

    always_comb begin
        rf_rw = '0;
        rf_pw = '0;
        if (count != '0) begin
            rf_rw = entries[head].rw;
            rf_pw = entries[head].pw;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry payload needs no reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (enq && !reset) begin
            entries[tail] <= '{rw: in_rw, pw: in_pw};
        end
    end

    wbuf_bypass #(.DEPTH(DEPTH)) u_bypass_a (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (ra),
        .rf_data (rf_pa),
        .data    (pa)
    );

    wbuf_bypass #(.DEPTH(DEPTH)) u_bypass_b (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (rb),
        .rf_data (rf_pb),
        .data    (pb)
    );

    wbuf_bypass #(.DEPTH(DEPTH)) u_bypass_d (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (rd),
        .rf_data (rf_pd),
        .data    (pd)
    );

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rw;
    logic [31:0] in_pw;
    logic        rf_hold;
    logic        rf_enable;
    logic [4:0]  rf_rw;
    logic [31:0] rf_pw;
    logic [4:0]  ra, rb, rd;
    logic [31:0] rf_pa, rf_pb, rf_pd;
    logic [31:0] pa, pb, pd;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    regfile_write_buffer #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rw     (in_rw),
        .in_pw     (in_pw),
        .rf_hold   (rf_hold),
        .rf_enable (rf_enable),
        .rf_rw     (rf_rw),
        .rf_pw     (rf_pw),
        .ra        (ra),
        .rb        (rb),
        .rd        (rd),
        .rf_pa     (rf_pa),
        .rf_pb     (rf_pb),
        .rf_pd     (rf_pd),
        .pa        (pa),
        .pb        (pb),
        .pd        (pd),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference queue for the streaming step: {rw, pw}.
    logic [36:0] exp_q [$];
    logic [4:0]  next_rw;
    logic        acc;
    logic        drn;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rw = '0; in_pw = '0; rf_hold = 1'b0;
        ra = '0; rb = '0; rd = '0;
        rf_pa = 32'h1111_0000; rf_pb = 32'h2222_0000; rf_pd = 32'h3333_0000;
        tick(); tick();
        reset = 1'b0;
        ra = 5'd5;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_enable", 32'(rf_enable), 32'd0);
        chk("rst_rf_rw", 32'(rf_rw), 32'd0);
        chk("rst_rf_pw", rf_pw, 32'd0);
        chk("rst_pa", pa, 32'h1111_0000);
        chk("rst_pb", pb, 32'h2222_0000);
        chk("rst_pd", pd, 32'h3333_0000);

        // Single write, next-cycle visibility and bypass before drain.
        in_valid = 1'b1; in_rw = 5'd5; in_pw = 32'hAAAA_0005;
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_rf_enable", 32'(rf_enable), 32'd1);
        chk("lat_rf_rw", 32'(rf_rw), 32'd5);
        chk("lat_rf_pw", rf_pw, 32'hAAAA_0005);
        chk("lat_pa_bypass", pa, 32'hAAAA_0005);
        tick();
        chk("lat_drained_count", 32'(count), 32'd0);
        chk("lat_drained_pa", pa, 32'h1111_0000);

        // Fill under hold, refuse a fifth offer, then drain in order.
        rf_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_rw = 5'(k); in_pw = 32'h100 + 32'(k);
            tick();
        end
        in_valid = 1'b1; in_rw = 5'd9; in_pw = 32'hDEAD_0009; ra = 5'd3;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_rf_enable", 32'(rf_enable), 32'd0);
        chk("full_pa_bypass", pa, 32'h103);
        tick();
        chk("full_refused_count", 32'(count), 32'd4);
        in_valid = 1'b0; rf_hold = 1'b0;
        #1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_rf_enable", 32'(rf_enable), 32'd1);
            chk("drain_rf_rw", 32'(rf_rw), 32'(k));
            chk("drain_rf_pw", rf_pw, 32'h100 + 32'(k));
            tick();
        end
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_rf_enable", 32'(rf_enable), 32'd0);

        // Duplicate addresses: youngest wins, both retained.
        rf_hold = 1'b1; rb = 5'd7;
        in_valid = 1'b1; in_rw = 5'd7; in_pw = 32'h11;
        tick();
        in_pw = 32'h22;
        tick();
        in_valid = 1'b0;
        #1;
        chk("dup_count", 32'(count), 32'd2);
        chk("dup_pb_youngest", pb, 32'h22);
        rf_hold = 1'b0;
        #1;
        chk("dup_first_pw", rf_pw, 32'h11);
        tick();
        chk("dup_mid_pb", pb, 32'h22);
        chk("dup_second_pw", rf_pw, 32'h22);
        tick();
        rf_pb = 32'h2222_BEEF;
        #1;
        chk("dup_done_count", 32'(count), 32'd0);
        chk("dup_done_pb", pb, 32'h2222_BEEF);

        // Writes to register 0 are accepted and dropped.
        in_valid = 1'b1; in_rw = 5'd0; in_pw = 32'hFFFF_FFFF; rd = 5'd0;
        #1;
        chk("r0_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_rf_enable", 32'(rf_enable), 32'd0);
        chk("r0_pd", pd, 32'h3333_0000);

        // Fill under hold, then stream with in_valid held high across wrap.
        rf_hold = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_rw = 5'(10 + k); in_pw = 32'h200 + 32'(k);
            exp_q.push_back({5'(10 + k), 32'h200 + 32'(k)});
            tick();
        end
        rf_hold = 1'b0;
        next_rw = 5'd14;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_rw = next_rw; in_pw = 32'h300 + 32'(next_rw);
            #1;
            chk("stream_count", 32'(count), 32'(exp_q.size()));
            chk("stream_in_ready", 32'(in_ready), 32'(exp_q.size() < 4));
            if (exp_q.size() > 0) begin
                chk("stream_rf_rw", 32'(rf_rw), 32'(exp_q[0][36:32]));
                chk("stream_rf_pw", rf_pw, exp_q[0][31:0]);
            end
            acc = (exp_q.size() < 4);
            drn = (exp_q.size() > 0);
            tick();
            if (drn) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({next_rw, 32'h300 + 32'(next_rw)});
                next_rw = next_rw + 5'd1;
            end
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            #1;
            chk("tail_rf_rw", 32'(rf_rw), 32'(exp_q[0][36:32]));
            chk("tail_rf_pw", rf_pw, exp_q[0][31:0]);
            tick();
            void'(exp_q.pop_front());
        end
        chk("stream_final_count", 32'(count), 32'd0);

        // Reset with pending writes dominates a simultaneous offer.
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_rw = 5'(20 + k); in_pw = 32'h400 + 32'(k);
            tick();
        end
        chk("prerst_count", 32'(count), 32'd3);
        reset = 1'b1; rf_hold = 1'b0; in_rw = 5'd25;
        tick();
        reset = 1'b0; in_valid = 1'b0; ra = 5'd20;
        #1;
        chk("rst3_count", 32'(count), 32'd0);
        chk("rst3_rf_enable", 32'(rf_enable), 32'd0);
        chk("rst3_in_ready", 32'(in_ready), 32'd1);
        chk("rst3_pa", pa, 32'h1111_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
